flit_packetizer: RTL

- Transmit-side network interface that converts a packet descriptor plus a stream of payload bytes into 10-bit flits.
- Drives the valid/ready/data input side of the elastic buffer, so it is the flit producer for that buffer.
- One-entry registered output stage; sustains one flit per cycle with no bubble between back-to-back packets.

---
 rtl/flit_packetizer_pkg.sv | 30 +++
 rtl/flit_out_reg.sv | 32 +++
 rtl/flit_packetizer.sv | 112 +++++++++++
 3 files changed

// File: rtl/flit_packetizer_pkg.sv
// Shared definitions for the flit packetizer: field widths, flit type codes,
// FSM state encoding and flit field positions.
package flit_packetizer_pkg;

    localparam int FLIT_W = 10;
    localparam int DEST_W = 4;
    localparam int LEN_W  = 4;

    // Flit field positions: [9:8] type, [7:0] payload
    localparam int TYPE_HI = 9;
    localparam int TYPE_LO = 8;
    localparam int PAY_HI  = 7;
    localparam int PAY_LO  = 0;

    localparam logic [1:0] FLIT_SINGLE = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_BODY   = 2'b10;
    localparam logic [1:0] FLIT_TAIL   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    function automatic logic [FLIT_W-1:0] make_flit(input logic [1:0] ftype,
                                                    input logic [7:0] payload);
        return {ftype, payload};
    endfunction

endpackage

// File: rtl/flit_out_reg.sv
// One-entry valid/ready register slice. Loads only when the slot is free,
// holds while the consumer stalls, and drains to empty on a handshake with
// nothing new to load.
module flit_out_reg #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         valid_out,
    input  logic         ready_in,
    output logic [W-1:0] data_out,
    output logic         free
);

    assign free = !valid_out || ready_in;

    // Slot register: refill or drain when free, otherwise hold contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (free) begin
            valid_out <= load;
            if (load) begin
                data_out <= load_data;
            end
        end
    end

endmodule

// File: rtl/flit_packetizer.sv
// Transmit-side packetizer: turns a descriptor plus payload bytes into
// HEAD/BODY/TAIL (or a lone SINGLE) flits through a one-entry output slice.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a descriptor; a len==0 descriptor is sent as SINGLE
// BODY  | HEAD issued; consuming payload bytes until remaining reaches 1
module flit_packetizer
    import flit_packetizer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [DEST_W-1:0] pkt_dest,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [7:0]        word_data,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [FLIT_W-1:0] data_out,
    output logic              pkt_done
);

    state_t             state, state_next;
    logic [LEN_W-1:0]   remaining, remaining_next;
    logic               load;
    logic [FLIT_W-1:0]  load_data;
    logic               free;
    logic               pkt_acc;
    logic               word_acc;
    logic               end_flit_hs;

    // Readies are gated by reset so nothing is accepted while it is held.
    assign pkt_ready  = !reset && (state == IDLE) && free;
    assign word_ready = !reset && (state == BODY) && free;
    assign pkt_acc    = pkt_valid && pkt_ready;
    assign word_acc   = word_valid && word_ready;

    assign end_flit_hs = valid_out && ready_in &&
                         ((data_out[TYPE_HI:TYPE_LO] == FLIT_TAIL) ||
                          (data_out[TYPE_HI:TYPE_LO] == FLIT_SINGLE));

    // State and remaining-byte down-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    // Next state, counter update and flit to load into the output slice.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        load           = 1'b0;
        load_data      = '0;
        case (state)
            IDLE: begin
                if (pkt_acc) begin
                    load = 1'b1;
                    if (pkt_len == '0) begin
                        load_data = make_flit(FLIT_SINGLE, {pkt_dest, pkt_len});
                    end else begin
                        load_data      = make_flit(FLIT_HEAD, {pkt_dest, pkt_len});
                        remaining_next = pkt_len;
                        state_next     = BODY;
                    end
                end
            end
            BODY: begin
                if (word_acc) begin
                    load = 1'b1;
                    if (remaining > LEN_W'(1)) begin
                        load_data      = make_flit(FLIT_BODY, word_data);
                        remaining_next = remaining - LEN_W'(1);
                    end else begin
                        load_data      = make_flit(FLIT_TAIL, word_data);
                        remaining_next = '0;
                        state_next     = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Packet-complete pulse, one cycle after the TAIL/SINGLE handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= end_flit_hs;
        end
    end

    flit_out_reg #(.W(FLIT_W)) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .free      (free)
    );

endmodule
